// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler
// Description : Holds one fetched instruction pair and issues it in order to
//               an even and an odd pipe. A per-register latency scoreboard
//               blocks instructions whose sources or destination are still
//               in flight.
//               Optional feature macro DUAL_ISSUE_EN: when defined, slot 2
//               may issue in the same cycle as slot 1; when undefined, slot 2
//               always issues in a later cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler #(
    parameter int NUM_REGS = 128,
    parameter int LAT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             pair_valid,
    output logic             pair_ready,
    input  logic             i2_valid,
    input  logic             i1_pipe,
    input  logic             i2_pipe,
    input  logic [6:0]       i1_rt,
    input  logic [6:0]       i2_rt,
    input  logic             i1_rt_we,
    input  logic             i2_rt_we,
    input  logic [6:0]       i1_ra,
    input  logic [6:0]       i1_rb,
    input  logic [6:0]       i1_rc,
    input  logic [6:0]       i2_ra,
    input  logic [6:0]       i2_rb,
    input  logic [6:0]       i2_rc,
    input  logic [2:0]       i1_src_use,
    input  logic [2:0]       i2_src_use,
    input  logic [LAT_W-1:0] i1_lat,
    input  logic [LAT_W-1:0] i2_lat,
    output logic             issue_even_valid,
    output logic             issue_odd_valid,
    output logic             issue_even_slot,
    output logic             issue_odd_slot,
    output logic             stall,
    output logic             dependency_stall_1,
    output logic             dependency_stall_2
);

    localparam int REG_W = 7;

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_PAIR   = 2'd1;
    localparam logic [1:0] S_SECOND = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    // Held copy of the accepted pair
    logic             r_h1_pipe, r_h2_pipe;
    logic [6:0]       r_h1_rt, r_h2_rt;
    logic             r_h1_we, r_h2_we;
    logic [6:0]       r_h1_ra, r_h1_rb, r_h1_rc;
    logic [6:0]       r_h2_ra, r_h2_rb, r_h2_rc;
    logic [2:0]       r_h1_src, r_h2_src;
    logic [LAT_W-1:0] r_h1_lat, r_h2_lat;
    logic             r_h2_valid;

    // Remaining cycles until each register's result is forwardable
    logic [LAT_W-1:0] r_sb [NUM_REGS];

    logic w_pend1, w_pend2;
    logic w_s1_ok, w_s2_ok;
    logic w_raw, w_waw, w_intra_ok;
    logic w_pair2, w_issue1, w_issue2;
    logic w_all_issued, w_accept;

    // A slot is pending in PAIR (slot 1, and slot 2 if it was valid) or SECOND
    assign w_pend1 = (r_state == S_PAIR);
    assign w_pend2 = (r_state == S_SECOND) || ((r_state == S_PAIR) && r_h2_valid);

    // Scoreboard readiness: every used source and a written rt must be idle
    assign w_s1_ok = (!r_h1_src[0] || (r_sb[r_h1_ra] == '0)) &&
                     (!r_h1_src[1] || (r_sb[r_h1_rb] == '0)) &&
                     (!r_h1_src[2] || (r_sb[r_h1_rc] == '0)) &&
                     (!r_h1_we     || (r_sb[r_h1_rt] == '0));
    assign w_s2_ok = (!r_h2_src[0] || (r_sb[r_h2_ra] == '0)) &&
                     (!r_h2_src[1] || (r_sb[r_h2_rb] == '0)) &&
                     (!r_h2_src[2] || (r_sb[r_h2_rc] == '0)) &&
                     (!r_h2_we     || (r_sb[r_h2_rt] == '0));

    // Intra-pair hazards: slot 2 reading slot 1's result, both writing one rt,
    // or both wanting the same pipe
    assign w_raw = r_h1_we && ((r_h2_src[0] && (r_h2_ra == r_h1_rt)) ||
                               (r_h2_src[1] && (r_h2_rb == r_h1_rt)) ||
                               (r_h2_src[2] && (r_h2_rc == r_h1_rt)));
    assign w_waw = r_h1_we && r_h2_we && (r_h1_rt == r_h2_rt);
    assign w_intra_ok = (r_h1_pipe != r_h2_pipe) && !w_raw && !w_waw;

`ifdef DUAL_ISSUE_EN
    assign w_pair2 = w_issue1 && w_intra_ok && w_s2_ok;
`else
    assign w_pair2 = 1'b0;
`endif

    assign w_issue1 = !flush && w_pend1 && w_s1_ok;
    assign w_issue2 = !flush && w_pend2 && (w_pend1 ? w_pair2 : w_s2_ok);

    // EMPTY has nothing pending, so it counts as fully issued
    assign w_all_issued = (!w_pend1 || w_issue1) && (!w_pend2 || w_issue2);
    assign pair_ready   = rst_n && !flush && w_all_issued;
    assign w_accept     = pair_valid && pair_ready;

    // Pipes never collide: slot 2 only joins slot 1 on the other pipe
    assign issue_even_valid = (w_issue1 && !r_h1_pipe) || (w_issue2 && !r_h2_pipe);
    assign issue_odd_valid  = (w_issue1 &&  r_h1_pipe) || (w_issue2 &&  r_h2_pipe);
    assign issue_even_slot  = w_issue2 && !r_h2_pipe;
    assign issue_odd_slot   = w_issue2 &&  r_h2_pipe;

    assign stall = (w_pend1 || w_pend2) && !w_issue1 && !w_issue2;
    assign dependency_stall_1 = !flush && w_pend1 && !w_s1_ok;
    assign dependency_stall_2 = !flush && w_pend2 &&
                                (w_pend1 ? (!w_s2_ok || !w_intra_ok) : !w_s2_ok);

    // Next holding state from flush, acceptance and what issued this cycle
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = S_PAIR;
        end else begin
            case (r_state)
                S_PAIR:   if (w_issue1) w_state_nxt = (w_pend2 && !w_issue2) ? S_SECOND : S_EMPTY;
                S_SECOND: if (w_issue2) w_state_nxt = S_EMPTY;
                default:  w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // State register and pair capture on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_h2_valid <= 1'b0;
            r_h1_pipe  <= 1'b0;  r_h2_pipe <= 1'b0;
            r_h1_rt    <= '0;    r_h2_rt   <= '0;
            r_h1_we    <= 1'b0;  r_h2_we   <= 1'b0;
            r_h1_ra    <= '0;    r_h1_rb   <= '0;  r_h1_rc <= '0;
            r_h2_ra    <= '0;    r_h2_rb   <= '0;  r_h2_rc <= '0;
            r_h1_src   <= '0;    r_h2_src  <= '0;
            r_h1_lat   <= '0;    r_h2_lat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_h2_valid <= i2_valid;
                r_h1_pipe  <= i1_pipe;    r_h2_pipe <= i2_pipe;
                r_h1_rt    <= i1_rt;      r_h2_rt   <= i2_rt;
                r_h1_we    <= i1_rt_we;   r_h2_we   <= i2_rt_we;
                r_h1_ra    <= i1_ra;      r_h1_rb   <= i1_rb;  r_h1_rc <= i1_rc;
                r_h2_ra    <= i2_ra;      r_h2_rb   <= i2_rb;  r_h2_rc <= i2_rc;
                r_h1_src   <= i1_src_use; r_h2_src  <= i2_src_use;
                r_h1_lat   <= i1_lat;     r_h2_lat  <= i2_lat;
            end
        end
    end

    // Scoreboard: issuing writer loads its latency, everything else counts down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_sb[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_issue1 && r_h1_we && (r_h1_rt == REG_W'(i)))
                    r_sb[i] <= r_h1_lat;
                else if (w_issue2 && r_h2_we && (r_h2_rt == REG_W'(i)))
                    r_sb[i] <= r_h2_lat;
                else if (r_sb[i] != '0)
                    r_sb[i] <= r_sb[i] - LAT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scheduler
// Description : Self-checking bench for dual_issue_scheduler. A reference
//               model tracks, per register, the absolute cycle at which its
//               result becomes forwardable, plus which held slots are still
//               pending; directed scenarios add literal expectations, then a
//               long randomized run is checked cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct packed {
        logic       pipe;
        logic [6:0] rt;
        logic       we;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic [2:0] srcs;
        logic [2:0] lat;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, pair_valid, i2_valid;
    ins_t in1, in2;
    logic pair_ready, issue_even_valid, issue_odd_valid, issue_even_slot, issue_odd_slot;
    logic stall, dependency_stall_1, dependency_stall_2;

    dual_issue_scheduler #(.NUM_REGS(128), .LAT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .pair_valid(pair_valid), .pair_ready(pair_ready), .i2_valid(i2_valid),
        .i1_pipe(in1.pipe), .i2_pipe(in2.pipe),
        .i1_rt(in1.rt), .i2_rt(in2.rt),
        .i1_rt_we(in1.we), .i2_rt_we(in2.we),
        .i1_ra(in1.ra), .i1_rb(in1.rb), .i1_rc(in1.rc),
        .i2_ra(in2.ra), .i2_rb(in2.rb), .i2_rc(in2.rc),
        .i1_src_use(in1.srcs), .i2_src_use(in2.srcs),
        .i1_lat(in1.lat), .i2_lat(in2.lat),
        .issue_even_valid(issue_even_valid), .issue_odd_valid(issue_odd_valid),
        .issue_even_slot(issue_even_slot), .issue_odd_slot(issue_odd_slot),
        .stall(stall),
        .dependency_stall_1(dependency_stall_1), .dependency_stall_2(dependency_stall_2)
    );

    // Model state
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ready_at [128];
    ins_t h1, h2;
    bit   p1 = 0, p2 = 0;
    bit   m_iss1, m_iss2, m_acc;

    function automatic bit rdy(logic [6:0] r);
        return cyc >= ready_at[r];
    endfunction

    function automatic bit sb_ok(ins_t x);
        return (!x.srcs[0] || rdy(x.ra)) && (!x.srcs[1] || rdy(x.rb)) &&
               (!x.srcs[2] || rdy(x.rc)) && (!x.we || rdy(x.rt));
    endfunction

    function automatic bit intra_ok(ins_t a, ins_t b);
        bit raw;
        raw = a.we && ((b.srcs[0] && b.ra == a.rt) || (b.srcs[1] && b.rb == a.rt) ||
                       (b.srcs[2] && b.rc == a.rt));
        return (a.pipe != b.pipe) && !raw && !(a.we && b.we && a.rt == b.rt);
    endfunction

    function automatic ins_t mk(bit pipe, int rt, bit we, int src, int srcs, int lat);
        ins_t x;
        x.pipe = pipe; x.rt = 7'(rt); x.we = we;
        x.ra = 7'(src); x.rb = 7'(src); x.rc = 7'(src);
        x.srcs = 3'(srcs); x.lat = 3'(lat);
        return x;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t x;
        x.pipe = 1'($urandom); x.rt = 7'($urandom_range(0, 7)); x.we = 1'($urandom);
        x.ra = 7'($urandom_range(0, 7)); x.rb = 7'($urandom_range(0, 7));
        x.rc = 7'($urandom_range(0, 7)); x.srcs = 3'($urandom);
        x.lat = 3'($urandom_range(1, 7));
        return x;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle();
        pair_valid = 0; flush = 0; i2_valid = 0; in1 = '0; in2 = '0;
    endtask

    // Settle, predict every output from the model, compare as one vector
    task automatic eval();
        bit e1, e2, d1, d2, rd, st, ev, es, ov, os, s1, s2, io;
        #1;
        {e1, e2, d1, d2, rd, st, ev, es, ov, os} = '0;
        if (rst_n) begin
            s1 = sb_ok(h1); s2 = sb_ok(h2); io = intra_ok(h1, h2);
            e1 = !flush && p1 && s1;
            e2 = !flush && p2 && (p1 ? (DUAL && e1 && io && s2) : s2);
            d1 = !flush && p1 && !s1;
            d2 = !flush && p2 && (p1 ? (!s2 || !io) : !s2);
            rd = !flush && (!p1 || e1) && (!p2 || e2);
            st = (p1 || p2) && !e1 && !e2;
            ev = (e1 && !h1.pipe) || (e2 && !h2.pipe);
            ov = (e1 &&  h1.pipe) || (e2 &&  h2.pipe);
            es = e2 && !h2.pipe;
            os = e2 &&  h2.pipe;
        end
        m_iss1 = e1; m_iss2 = e2; m_acc = rd && pair_valid;
        chk("outputs{rdy,ev,es,ov,os,stall,dep1,dep2}",
            {pair_ready, issue_even_valid, issue_even_slot, issue_odd_valid,
             issue_odd_slot, stall, dependency_stall_1, dependency_stall_2},
            {rd, ev, es, ov, os, st, d1, d2});
    endtask

    // Apply this cycle's effects to the model at the clock edge
    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) ready_at[i] = 0;
            p1 = 0; p2 = 0;
        end else begin
            if (m_iss1 && h1.we) ready_at[h1.rt] = cyc + 1 + int'(h1.lat);
            if (m_iss2 && h2.we) ready_at[h2.rt] = cyc + 1 + int'(h2.lat);
            if (flush) begin
                p1 = 0; p2 = 0;
            end else if (m_acc) begin
                h1 = in1; h2 = in2; p1 = 1; p2 = i2_valid;
            end else begin
                if (m_iss1) p1 = 0;
                if (m_iss2) p2 = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        repeat (10) begin eval(); advance(); end
    endtask

    initial begin
        rst_n = 0; idle();
        for (int i = 0; i < 128; i++) ready_at[i] = 0;
        @(negedge clk);
        eval();
        chk("reset_pair_ready", pair_ready, 0);
        chk("reset_stall", stall, 0);
        advance();
        rst_n = 1;

        // Independent pair on different pipes
        in1 = mk(0, 5, 1, 1, 3'b011, 2); in2 = mk(1, 6, 1, 2, 3'b001, 3);
        i2_valid = 1; pair_valid = 1;
        eval(); chk("a_accept", pair_ready, 1); advance(); idle();
        eval();
        chk("a_even_valid", issue_even_valid, 1); chk("a_even_slot", issue_even_slot, 0);
        chk("a_odd_valid", issue_odd_valid, DUAL); chk("a_odd_slot", issue_odd_slot, DUAL);
        advance();
        eval();
        chk("a_odd_valid_next", issue_odd_valid, !DUAL);
        chk("a_odd_slot_next", issue_odd_slot, !DUAL);
        chk("a_stall_next", stall, 0);
        advance(); drain();

        // Both slots want the even pipe
        in1 = mk(0, 20, 1, 1, 0, 1); in2 = mk(0, 21, 1, 2, 0, 1);
        i2_valid = 1; pair_valid = 1;
        eval(); advance(); idle();
        eval();
        chk("b_even_valid", issue_even_valid, 1); chk("b_even_slot", issue_even_slot, 0);
        chk("b_dep2", dependency_stall_2, 1); chk("b_odd_valid", issue_odd_valid, 0);
        advance();
        eval();
        chk("b_even_valid2", issue_even_valid, 1); chk("b_even_slot2", issue_even_slot, 1);
        advance(); drain();

        // Slot 2 reads r10 written by slot 1 with latency 4: four stalled cycles
        in1 = mk(1, 10, 1, 0, 0, 4); in2 = mk(0, 11, 1, 10, 3'b001, 1);
        i2_valid = 1; pair_valid = 1;
        eval(); advance(); idle();
        eval();
        chk("c_odd_valid", issue_odd_valid, 1); chk("c_odd_slot", issue_odd_slot, 0);
        chk("c_dep2", dependency_stall_2, 1); chk("c_even_valid", issue_even_valid, 0);
        advance();
        for (int k = 0; k < 4; k++) begin
            eval(); chk("c_stall", stall, 1); chk("c_no_issue", issue_even_valid, 0);
            advance();
        end
        eval();
        chk("c_late_issue", issue_even_valid, 1); chk("c_late_slot", issue_even_slot, 1);
        chk("c_late_stall", stall, 0);
        advance(); drain();

        // r3 writer lat 7 outstanding; next i1 reads r3
        in1 = mk(0, 3, 1, 0, 0, 7); i2_valid = 0; pair_valid = 1;
        eval(); advance();
        in1 = mk(0, 12, 1, 3, 3'b001, 1); pair_valid = 1;
        eval(); chk("d_writer_issue", issue_even_valid, 1); chk("d_accept", pair_ready, 1);
        advance();
        in1 = mk(1, 0, 0, 0, 0, 1); pair_valid = 1;
        for (int k = 0; k < 7; k++) begin
            eval();
            chk("d_dep1", dependency_stall_1, 1); chk("d_not_ready", pair_ready, 0);
            chk("d_no_issue", issue_even_valid, 0);
            advance();
        end
        eval();
        chk("d_issue", issue_even_valid, 1); chk("d_dep1_clear", dependency_stall_1, 0);
        chk("d_ready", pair_ready, 1);
        advance(); drain();

        // Flush while in SECOND; r30 counter keeps running
        in1 = mk(0, 30, 1, 0, 0, 7); in2 = mk(0, 31, 0, 0, 0, 1);
        i2_valid = 1; pair_valid = 1;
        eval(); advance(); idle();
        eval(); chk("e_slot1", issue_even_valid, 1); advance();
        flush = 1; pair_valid = 1; in1 = mk(0, 0, 0, 0, 0, 1);
        eval();
        chk("e_flush_even", issue_even_valid, 0); chk("e_flush_odd", issue_odd_valid, 0);
        chk("e_flush_ready", pair_ready, 0);
        advance();
        flush = 0; pair_valid = 1; i2_valid = 0; in1 = mk(0, 13, 0, 30, 3'b001, 1);
        eval(); chk("e_empty_ready", pair_ready, 1); chk("e_empty_stall", stall, 0);
        advance(); idle();
        for (int k = 0; k < 5; k++) begin
            eval(); chk("e_dep1", dependency_stall_1, 1); advance();
        end
        eval(); chk("e_issue", issue_even_valid, 1); advance(); drain();

        // Reset asserted mid-PAIR
        in1 = mk(0, 50, 1, 0, 0, 7); i2_valid = 0; pair_valid = 1;
        eval(); advance();
        in1 = mk(0, 14, 0, 50, 3'b001, 1); pair_valid = 1;
        eval(); advance(); idle();
        eval(); chk("f_blocked", dependency_stall_1, 1); advance();
        rst_n = 0;
        eval();
        chk("f_reset_outs", {pair_ready, issue_even_valid, issue_odd_valid, stall,
                             dependency_stall_1, dependency_stall_2}, 8'h00);
        advance();
        rst_n = 1; in1 = mk(0, 14, 0, 50, 3'b001, 1); pair_valid = 1;
        eval(); chk("f_accept", pair_ready, 1); advance(); idle();
        eval(); chk("f_issue_cleared", issue_even_valid, 1); advance(); drain();

        // Randomized run
        for (int n = 0; n < 4000; n++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            pair_valid = ($urandom_range(0, 3) != 0);
            i2_valid   = ($urandom_range(0, 3) != 0);
            in1 = rnd_ins(); in2 = rnd_ins();
            eval(); advance();
        end
        rst_n = 1; drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
